// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with a 2-entry skid buffer, flush and stall counter.
// Latency: 1 cycle from in_fire to out_valid; full throughput with out_ready high.
// Backpressure: registered in_ready drops once the skid entry is occupied; skid absorbs the in-flight beat.
module ex_mem_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     store_data_in,
  input  logic [REG_ADDR_W-1:0] wr_reg_in,
  input  logic [CTRL_W-1:0]     ctrl_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [DATA_W-1:0]     store_data_out,
  output logic [REG_ADDR_W-1:0] wr_reg_out,
  output logic [CTRL_W-1:0]     ctrl_out,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] SKID  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [DATA_W-1:0]     main_alu_q, main_alu_d, skid_alu_q, skid_alu_d;
  logic [DATA_W-1:0]     main_st_q, main_st_d, skid_st_q, skid_st_d;
  logic [REG_ADDR_W-1:0] main_wr_q, main_wr_d, skid_wr_q, skid_wr_d;
  logic [CTRL_W-1:0]     main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]      stall_q, stall_d;

  logic out_valid_w;
  logic in_fire;
  logic out_fire;

  assign out_valid_w = (state_q != EMPTY);
  assign in_fire     = in_valid & in_ready_q;
  assign out_fire    = out_valid_w & out_ready;

  // Next-state: entry movement between input, main and skid; flush overrides all moves.
  always_comb begin
    state_d     = state_q;
    main_alu_d  = main_alu_q;
    main_st_d   = main_st_q;
    main_wr_d   = main_wr_q;
    main_ctrl_d = main_ctrl_q;
    skid_alu_d  = skid_alu_q;
    skid_st_d   = skid_st_q;
    skid_wr_d   = skid_wr_q;
    skid_ctrl_d = skid_ctrl_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_alu_d  = alu_result_in;
          main_st_d   = store_data_in;
          main_wr_d   = wr_reg_in;
          main_ctrl_d = ctrl_in;
          state_d     = FULL;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          main_alu_d  = alu_result_in;
          main_st_d   = store_data_in;
          main_wr_d   = wr_reg_in;
          main_ctrl_d = ctrl_in;
        end else if (in_fire) begin
          skid_alu_d  = alu_result_in;
          skid_st_d   = store_data_in;
          skid_wr_d   = wr_reg_in;
          skid_ctrl_d = ctrl_in;
          state_d     = SKID;
        end else if (out_fire) begin
          // Keep ctrl_out at zero whenever nothing valid is presented.
          main_ctrl_d = '0;
          state_d     = EMPTY;
        end
      end
      SKID: begin
        if (out_fire) begin
          main_alu_d  = skid_alu_q;
          main_st_d   = skid_st_q;
          main_wr_d   = skid_wr_q;
          main_ctrl_d = skid_ctrl_q;
          state_d     = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush discards everything, including a beat accepted this cycle; data stays stale.
    if (flush) begin
      state_d     = EMPTY;
      main_alu_d  = main_alu_q;
      main_st_d   = main_st_q;
      main_wr_d   = main_wr_q;
      skid_alu_d  = skid_alu_q;
      skid_st_d   = skid_st_q;
      skid_wr_d   = skid_wr_q;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end
  end

  // Ready is registered from the next state so no input-to-ready combinational path exists.
  always_comb begin
    in_ready_d = (state_d != SKID);
  end

  // Stall counter saturates at all-ones; only reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (out_valid_w && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      main_alu_q  <= '0;
      main_st_q   <= '0;
      main_wr_q   <= '0;
      main_ctrl_q <= '0;
      skid_alu_q  <= '0;
      skid_st_q   <= '0;
      skid_wr_q   <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_alu_q  <= main_alu_d;
      main_st_q   <= main_st_d;
      main_wr_q   <= main_wr_d;
      main_ctrl_q <= main_ctrl_d;
      skid_alu_q  <= skid_alu_d;
      skid_st_q   <= skid_st_d;
      skid_wr_q   <= skid_wr_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_q     <= stall_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_w;
  assign alu_result_out = main_alu_q;
  assign store_data_out = main_st_q;
  assign wr_reg_out     = main_wr_q;
  assign ctrl_out       = main_ctrl_q;
  assign occupancy      = state_q;
  assign stall_cnt      = stall_q;

endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised EX→MEM pipeline register with valid/ready handshake, a 2-entry skid buffer, a synchronous flush and a saturating back-pressure counter. It carries the ALU result, store data, destination register and a packed control bundle from the execute stage to the memory stage. Unlike a plain always-load register, it lets the MEM stage stall and lets the hazard unit kill in-flight instructions without losing or duplicating data.

## Interface
- DATA_W, 32: width of ALU result and store data.
- REG_ADDR_W, 5: width of destination register index.
- CTRL_W, 8: width of control bundle; bit order {Zero, Jump, RegWrite, MemWrite, MemToReg, MemRead, BranchNE, BranchEQ} (bit 0 = BranchEQ).
- CNT_W, 16: width of stall counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill all held entries this cycle.
- in_valid  in  1  EX stage presents an instruction.
- in_ready  out  1  block can accept; registered.
- alu_result_in  in  DATA_W  ALU result.
- store_data_in  in  DATA_W  rt read data for stores.
- wr_reg_in  in  REG_ADDR_W  destination register.
- ctrl_in  in  CTRL_W  control bundle.
- out_valid  out  1  MEM stage entry valid.
- out_ready  in  1  MEM stage accepts.
- alu_result_out, store_data_out  out  DATA_W  held entry.
- wr_reg_out  out  REG_ADDR_W  held entry.
- ctrl_out  out  CTRL_W  held entry; forced 0 whenever out_valid=0.
- occupancy  out  2  entries held (0, 1, 2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry. States: EMPTY (occupancy 0), FULL (1), SKID (2).
- EMPTY: in_fire → load main, go FULL.
- FULL: in_fire & out_fire → load main with input, stay FULL; in_fire & !out_fire → load skid, go SKID; !in_fire & out_fire → go EMPTY, clear ctrl_out; otherwise hold.
- SKID: in_ready=0, so no in_fire; out_fire → main ← skid, go FULL; otherwise hold.
- flush=1: next state EMPTY, ctrl_out and the skid ctrl cleared, any in_fire that cycle is discarded. Flush overrides every transition above. Data fields may keep stale values; only ctrl and valid are guaranteed cleared.
- in_ready register next value = (next state != SKID).
- stall_cnt increments when out_valid & !out_ready, holds at 2^CNT_W−1, and is cleared only by rst (flush does not clear it).
- Data and ctrl are never modified in flight; entries leave in arrival order.

## Timing
- Latency: input accepted at edge N appears on outputs with out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle with out_ready held high; no bubbles.
- in_ready is registered: it drops the cycle after the skid fills and rises the cycle after the skid drains. The skid entry absorbs the one transfer in flight.
- Reset (rst=1 at edge): state EMPTY, out_valid=0, in_ready=0, all data/ctrl/wr_reg outputs 0, occupancy=0, stall_cnt=0. in_ready rises at the first edge with rst=0.
- rst mid-operation drops all entries; rst has priority over flush.
- Simultaneous flush and out_ready: the entry on the outputs is considered consumed by MEM only if the MEM stage itself ignores flush; this block counts it as dropped.
- Combinational paths: out_valid, in_ready and ctrl_out come straight from registers; there is no path from in_* to out_*.

## Test plan
- Reset then stream: rst for 2 cycles, then 4 back-to-back inputs with alu_result_in=0x10,0x20,0x30,0x40 and out_ready=1 → outputs show the same values on consecutive cycles, 1-cycle latency, occupancy never exceeds 1, stall_cnt=0.
- Back-pressure: out_ready=0 while sending 0xA, 0xB → occupancy=2, in_ready=0 from the next cycle. Raise out_ready → 0xA then 0xB delivered, nothing lost or duplicated, stall_cnt equals the stalled cycles.
- Flush in SKID: hold two entries with ctrl_in=0x30 (RegWrite|MemWrite) and assert flush for 1 cycle → out_valid=0, ctrl_out=0x00, occupancy=0, in_ready=1 next cycle.
- Flush with in_fire: in_valid=1 with 0x55 while flush=1 → 0x55 never appears on the outputs.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with one entry held → stall_cnt sticks at 15.
- Reset mid-stall: occupancy=2, assert rst → all outputs 0 next cycle, in_ready=0, then in_ready=1 one cycle after release.
